// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
//   fetch_entry_t : one buffered {pc, inst} pair
//   INST_W        : instruction width
//   FETCH_WIDTH   : instructions fetched / delivered per cycle
//   RESET_PC_DEFAULT : default fetch PC after reset
package fetch_pkg;

  localparam int unsigned INST_W      = 32;
  localparam int unsigned FETCH_WIDTH = 2;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0]       pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular fetch queue: writes up to two entries and exposes the two oldest entries per cycle.
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   flush_i           discard all entries (wins over push and pop)
//   push_i            write both push_data_i entries ([0] is older)
//   push_data_i       pair of entries to append
//   take_i            entries consumed this cycle; clamped to the number of valid slots
//   valid_o           slot valid: 00, 01 or 11
//   head_o            [0] = oldest entry, [1] = next; zero when the slot is invalid
//   space_o           at least two free entries (registered count <= Depth-2)
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned Depth = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  fetch_entry_t [1:0]    push_data_i,
  input  logic [1:0]            take_i,
  output logic [1:0]            valid_o,
  output fetch_entry_t [1:0]    head_o,
  output logic                  space_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  fetch_entry_t    mem_q [Depth];
  logic [PtrW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [1:0]      take_eff;
  logic [PtrW-1:0] rd_p1, wr_p1;
  logic            do_push;

  // Pointers are exactly log2(Depth) bits, so +1 wraps modulo Depth for free.
  assign rd_p1   = rd_q + PtrW'(1);
  assign wr_p1   = wr_q + PtrW'(1);
  assign do_push = push_i & ~flush_i;

  assign valid_o = (count_q >= CntW'(2)) ? 2'b11 :
                   (count_q == CntW'(1)) ? 2'b01 : 2'b00;
  assign space_o = (count_q <= CntW'(Depth - 2));

  assign head_o[0] = valid_o[0] ? mem_q[rd_q]  : '0;
  assign head_o[1] = valid_o[1] ? mem_q[rd_p1] : '0;

  // Consumers may ask for more than is valid (or the illegal value 3); never pop past count.
  always_comb begin
    take_eff = 2'd0;
    if (count_q == CntW'(0)) begin
      take_eff = 2'd0;
    end else if (count_q == CntW'(1)) begin
      take_eff = (take_i != 2'd0) ? 2'd1 : 2'd0;
    end else begin
      take_eff = (take_i == 2'd3) ? 2'd2 : take_i;
    end
  end

  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    if (flush_i) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end else begin
      rd_d    = rd_q + PtrW'(take_eff);
      wr_d    = do_push ? (wr_q + PtrW'(2)) : wr_q;
      count_d = count_q + (do_push ? CntW'(2) : CntW'(0)) - CntW'(take_eff);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      if (do_push) begin
        mem_q[wr_q]  <= push_data_i[0];
        mem_q[wr_p1] <= push_data_i[1];
      end
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, pushes dual-word fetches into a fetch queue and
// delivers up to two in-order instructions per cycle to decode. Redirects flush the queue.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned redirect raises fetch_fault_o
// and halts fetch until the next redirect). Without it, redirect targets are word-aligned.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   imem_pc_o       fetch PC to instruction memory
//   imem_inst_i     [0]=word at imem_pc_o, [1]=word at imem_pc_o+4 (combinational return)
//   redirect_i      taken branch/jump: flush and refetch from redirect_pc_i
//   redirect_pc_i   redirect target
//   dec_valid_o     slot valid (00, 01, 11), slot0 older
//   dec_inst_o      instruction per slot
//   dec_pc_o        PC per slot
//   dec_take_i      instructions consumed this cycle (0..2)
//   fetch_fault_o   misaligned redirect trap
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned QDEPTH   = 8
) (
  input  logic             clk,
  input  logic             rst,
  output logic [31:0]      imem_pc_o,
  input  logic [1:0][31:0] imem_inst_i,
  input  logic             redirect_i,
  input  logic [31:0]      redirect_pc_i,
  output logic [1:0]       dec_valid_o,
  output logic [1:0][31:0] dec_inst_o,
  output logic [1:0][31:0] dec_pc_o,
  input  logic [1:0]       dec_take_i,
  output logic             fetch_fault_o
);

  logic [31:0]        pc_q, pc_d;
  logic               halt;
  logic               space;
  logic               push;
  fetch_entry_t [1:0] push_data;
  fetch_entry_t [1:0] head;
  logic [31:0]        target;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic fault_q, fault_d;

  assign target = redirect_pc_i;
  assign halt   = fault_q;

  // Every redirect re-evaluates the fault, so an aligned redirect clears it.
  always_comb begin
    fault_d = fault_q;
    if (redirect_i) begin
      fault_d = (redirect_pc_i[1:0] != 2'b00);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  assign fetch_fault_o = fault_q;
`else
  assign target        = redirect_pc_i & ~32'h3;
  assign halt          = 1'b0;
  assign fetch_fault_o = 1'b0;
`endif

  assign push = ~redirect_i & space & ~halt;

  assign push_data[0].pc   = pc_q;
  assign push_data[0].inst = imem_inst_i[0];
  assign push_data[1].pc   = pc_q + 32'd4;
  assign push_data[1].inst = imem_inst_i[1];

  always_comb begin
    pc_d = pc_q;
    if (redirect_i) begin
      pc_d = target;
    end else if (push) begin
      pc_d = pc_q + 32'd8;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign imem_pc_o = pc_q;

  fetch_queue #(
    .Depth (QDEPTH)
  ) u_queue (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (redirect_i),
    .push_i      (push),
    .push_data_i (push_data),
    .take_i      (dec_take_i),
    .valid_o     (dec_valid_o),
    .head_o      (head),
    .space_o     (space)
  );

  assign dec_pc_o[0]   = head[0].pc;
  assign dec_pc_o[1]   = head[1].pc;
  assign dec_inst_o[0] = head[0].inst;
  assign dec_inst_o[1] = head[1].inst;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus randomized redirects/takes,
// checked every cycle against a queue-based model of the fetch behaviour.
module tb_instruction_fetch_unit;

  localparam int unsigned QD = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [31:0]      imem_pc_o;
  logic [1:0][31:0] imem_inst_i;
  logic             redirect_i = 1'b0;
  logic [31:0]      redirect_pc_i = '0;
  logic [1:0]       dec_valid_o;
  logic [1:0][31:0] dec_inst_o;
  logic [1:0][31:0] dec_pc_o;
  logic [1:0]       dec_take_i = 2'd0;
  logic             fetch_fault_o;

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;

  instruction_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .QDEPTH   (QD)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_pc_o     (imem_pc_o),
    .imem_inst_i   (imem_inst_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .dec_valid_o   (dec_valid_o),
    .dec_inst_o    (dec_inst_o),
    .dec_pc_o      (dec_pc_o),
    .dec_take_i    (dec_take_i),
    .fetch_fault_o (fetch_fault_o)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: an arbitrary function of the address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, a[31:16] + 16'h1234} ^ (a << 3);
  endfunction

  assign imem_inst_i[0] = memf(imem_pc_o);
  assign imem_inst_i[1] = memf(imem_pc_o + 32'd4);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
  ent_t        mq[$];
  logic [31:0] m_pc    = '0;
  bit          m_fault = 1'b0;
  int          m_nv, m_tk;
  bit          m_fetch;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_pc    = 32'h0;
      m_fault = 1'b0;
    end else begin
      m_nv = (mq.size() >= 2) ? 2 : mq.size();
      m_tk = (dec_take_i == 2'd3) ? 2 : int'(dec_take_i);
      if (m_tk > m_nv) m_tk = m_nv;
      if (redirect_i) begin
        mq.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
        m_pc    = redirect_pc_i;
        m_fault = (redirect_pc_i % 4) != 0;
`else
        m_pc    = redirect_pc_i - (redirect_pc_i % 4);
`endif
      end else begin
        m_fetch = (mq.size() <= QD - 2) && !m_fault;
        repeat (m_tk) void'(mq.pop_front());
        if (m_fetch) begin
          mq.push_back('{pc: m_pc, inst: memf(m_pc)});
          mq.push_back('{pc: m_pc + 32'd4, inst: memf(m_pc + 32'd4)});
          m_pc = m_pc + 32'd8;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("valid", {62'd0, dec_valid_o},
          (mq.size() >= 2) ? 64'd3 : (mq.size() == 1) ? 64'd1 : 64'd0);
      chk("imem_pc", {32'd0, imem_pc_o}, {32'd0, m_pc});
      chk("fault", {63'd0, fetch_fault_o}, {63'd0, m_fault});
      for (int i = 0; i < 2; i++) begin
        if (mq.size() > i) begin
          chk("slot_pc", {32'd0, dec_pc_o[i]}, {32'd0, mq[i].pc});
          chk("slot_inst", {32'd0, dec_inst_o[i]}, {32'd0, mq[i].inst});
        end
      end
    end
  end

  // Drive one cycle of inputs; returns shortly after the edge they are sampled on.
  task automatic step(input bit r, input logic [31:0] t, input logic [1:0] tk);
    redirect_i    = r;
    redirect_pc_i = t;
    dec_take_i    = tk;
    @(posedge clk);
    #2;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_pc"}, {32'd0, imem_pc_o}, 64'd0);
    chk({tag, "_valid"}, {62'd0, dec_valid_o}, 64'd0);
    chk({tag, "_decpc"}, dec_pc_o, 64'd0);
    chk({tag, "_decinst"}, dec_inst_o, 64'd0);
    chk({tag, "_fault"}, {63'd0, fetch_fault_o}, 64'd0);
  endtask

  initial begin
    #2;
    check_reset_vals("reset");
    #10 rst = 1'b0;             // release at t=12, first active edge at t=15
    chk_en = 1'b1;

    // 1: no consumption -> four fetches (counts 0,2,4,6) then stall at PC 32
    repeat (6) step(0, 0, 2'd0);
    chk("fill_pc", {32'd0, imem_pc_o}, 64'd32);
    chk("fill_valid", {62'd0, dec_valid_o}, 64'd3);
    chk("fill_slot0", {32'd0, dec_pc_o[0]}, 64'd0);
    chk("fill_slot1", {32'd0, dec_pc_o[1]}, 64'd4);
    chk("fill_inst1", {32'd0, dec_inst_o[1]}, {32'd0, memf(32'd4)});

    // 2: take 2 per cycle; 3: take 1 per cycle, crossing pointer wrap repeatedly
    repeat (12) step(0, 0, 2'd2);
    repeat (24) step(0, 0, 2'd1);

    // 4: redirect with a partly full queue
    repeat (3) step(0, 0, 2'd0);
    step(1, 32'h100, 2'd0);
    chk("redir_valid", {62'd0, dec_valid_o}, 64'd0);
    chk("redir_pc", {32'd0, imem_pc_o}, 64'h100);
    step(0, 0, 2'd0);
    chk("redir_slot0", {32'd0, dec_pc_o[0]}, 64'h100);
    chk("redir_slot1", {32'd0, dec_pc_o[1]}, 64'h104);
    chk("redir_valid2", {62'd0, dec_valid_o}, 64'd3);

    // 5: redirect together with take=2, then asynchronous reset mid-cycle
    repeat (2) step(0, 0, 2'd1);
    step(1, 32'h40, 2'd2);
    chk("redir_take_valid", {62'd0, dec_valid_o}, 64'd0);
    repeat (3) step(0, 0, 2'd1);
    rst = 1'b1;
    #1;
    check_reset_vals("async_rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) step(0, 0, 2'd2);

    // PC wrap past 2^32
    step(1, 32'hFFFF_FFF0, 2'd0);
    repeat (3) step(0, 0, 2'd1);

    // 6: misaligned redirect
    step(1, 32'h102, 2'd0);
    repeat (3) step(0, 0, 2'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("mis_fault", {63'd0, fetch_fault_o}, 64'd1);
    chk("mis_pc", {32'd0, imem_pc_o}, 64'h102);
    chk("mis_valid", {62'd0, dec_valid_o}, 64'd0);
`else
    chk("mis_fault", {63'd0, fetch_fault_o}, 64'd0);
    chk("mis_pc", {32'd0, imem_pc_o}, 64'h118);
    chk("mis_slot0", {32'd0, dec_pc_o[0]}, 64'h100);
`endif
    step(1, 32'h200, 2'd0);
    step(0, 0, 2'd0);
    chk("clear_fault", {63'd0, fetch_fault_o}, 64'd0);
    chk("clear_slot0", {32'd0, dec_pc_o[0]}, 64'h200);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [31:0] t;
      t = $urandom;
      if ($urandom_range(0, 7) != 0) t = t & ~32'h3;
      step(($urandom_range(0, 15) == 0), t, 2'($urandom_range(0, 2)));
    end
    step(0, 0, 2'd0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
